// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the sequential ALU.
//   - 4-bit operation codes driven on alu_seq_unit.op
//   - FSM state encoding (IDLE/BUSY/DONE), also visible on the debug port
//   - is_iter_op(): true for the ops that run through the iterative unit
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;   // low W bits of the product
  localparam logic [3:0] OP_DIV  = 4'd3;   // unsigned quotient
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_NOT  = 4'd7;   // ~a
  localparam logic [3:0] OP_SLL  = 4'd8;   // a << b[4:0]
  localparam logic [3:0] OP_SRL  = 4'd9;   // logical a >> b[4:0]
  localparam logic [3:0] OP_SRA  = 4'd10;  // arithmetic a >>> b[4:0]
  localparam logic [3:0] OP_INC  = 4'd11;
  localparam logic [3:0] OP_DEC  = 4'd12;
  localparam logic [3:0] OP_POPC = 4'd13;  // codes 14 and 15 return 0

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  function automatic logic is_iter_op(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// alu_iter_muldiv: W-cycle iterative multiply (shift-add) and unsigned
// restoring divide.
//   clk, rst  : clock, synchronous active-high reset (abandons any operation)
//   start_i   : one-cycle pulse; loads a_i/b_i and starts W iterations
//   is_div_i  : sampled with start_i; 1 = divide a_i / b_i, 0 = multiply
//   a_i, b_i  : operands (multiplicand/multiplier or dividend/divisor)
//   done_o    : high during the cycle whose clock edge completes the last
//               iteration; res_o then carries the final value, so the
//               caller registers it on that same edge
//   res_o     : low W bits of the product, or the quotient
module alu_iter_muldiv #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic         is_div_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic         done_o,
  output logic [W-1:0] res_o
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  // Multiply: acc = partial product, x = shifted multiplicand, y = multiplier.
  // Divide:   acc = partial remainder, x = divisor, y = dividend shifting out
  //           at the top while quotient bits shift in at the bottom.
  logic          busy_q;
  logic          is_div_q;
  logic [CW-1:0] cnt_q;
  logic [W-1:0]  acc_q, x_q, y_q;

  logic [W-1:0]  acc_d, x_d, y_d;
  logic [W:0]    rem_sh, diff;

  always_comb begin
    acc_d  = acc_q;
    x_d    = x_q;
    y_d    = y_q;
    rem_sh = '0;
    diff   = '0;
    if (is_div_q) begin
      rem_sh = {acc_q, y_q[W-1]};
      diff   = rem_sh - {1'b0, x_q};
      // Divisor 0 never makes diff negative, so every quotient bit is 1:
      // divide-by-zero yields all-ones without a special case.
      if (!diff[W]) begin
        acc_d = diff[W-1:0];
        y_d   = {y_q[W-2:0], 1'b1};
      end else begin
        acc_d = rem_sh[W-1:0];
        y_d   = {y_q[W-2:0], 1'b0};
      end
    end else begin
      if (y_q[0]) acc_d = acc_q + x_q;
      x_d = x_q << 1;
      y_d = y_q >> 1;
    end
  end

  assign done_o = busy_q && (cnt_q == LAST);
  assign res_o  = is_div_q ? y_d : acc_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q   <= 1'b0;
      is_div_q <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
    end else if (start_i) begin
      busy_q   <= 1'b1;
      is_div_q <= is_div_i;
      cnt_q    <= '0;
      acc_q    <= '0;
      if (is_div_i) begin
        x_q <= b_i;
        y_q <= a_i;
      end else begin
        x_q <= a_i;
        y_q <= b_i;
      end
    end else if (busy_q) begin
      acc_q <= acc_d;
      x_q   <= x_d;
      y_q   <= y_d;
      if (cnt_q == LAST) begin
        busy_q <= 1'b0;
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/alu_seq_unit.sv
// alu_seq_unit: sequential ALU with a valid/ready request and result port.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : request handshake; a, b, op captured on accept
//   a, b, op            : operands and operation code (see alu_pkg)
//   out_valid/out_ready : result handshake
//   r                   : result, forced to 0 while out_valid is low
//   dbg_state_o         : current FSM state
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// in_ready is high only in IDLE. out_valid and r stay constant in DONE until
// out_ready is seen; that edge returns to IDLE, so the next request can be
// accepted one cycle later at the earliest. Inputs are ignored outside IDLE.
//
// Single-cycle ops are computed from the inputs at the accept edge and land
// directly in DONE (out_valid one cycle later). Multiply and divide spend W
// cycles in BUSY inside alu_iter_muldiv, giving out_valid W+1 cycles later.
module alu_seq_unit
  import alu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [3:0]   op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] r,
  output alu_state_e   dbg_state_o
);

  alu_state_e   state_q;
  logic         out_valid_q;
  logic [W-1:0] r_q;

  logic         accept;
  logic         md_start;
  logic         md_done;
  logic [W-1:0] md_res;
  logic [W-1:0] single_res;
  logic [4:0]   shamt;

  function automatic logic [W-1:0] popcount(input logic [W-1:0] v);
    logic [W-1:0] c;
    c = '0;
    for (int i = 0; i < W; i++) c = c + W'(v[i]);
    return c;
  endfunction

  assign in_ready    = (state_q == ST_IDLE);
  assign accept      = in_valid && in_ready;
  assign md_start    = accept && is_iter_op(op);
  assign out_valid   = out_valid_q;
  assign r           = r_q;
  assign dbg_state_o = state_q;
  assign shamt       = b[4:0];

  // All arithmetic wraps modulo 2^W; no flags are produced.
  always_comb begin
    single_res = '0;
    unique case (op)
      OP_ADD:  single_res = a + b;
      OP_SUB:  single_res = a - b;
      OP_AND:  single_res = a & b;
      OP_OR:   single_res = a | b;
      OP_XOR:  single_res = a ^ b;
      OP_NOT:  single_res = ~a;
      OP_SLL:  single_res = a << shamt;
      OP_SRL:  single_res = a >> shamt;
      OP_SRA:  single_res = $signed(a) >>> shamt;
      OP_INC:  single_res = a + W'(1);
      OP_DEC:  single_res = a - W'(1);
      OP_POPC: single_res = popcount(a);
      default: single_res = '0;  // 2/3 go through the iterative unit; 14/15 give 0
    endcase
  end

  alu_iter_muldiv #(.W(W)) u_muldiv (
    .clk      (clk),
    .rst      (rst),
    .start_i  (md_start),
    .is_div_i (op == OP_DIV),
    .a_i      (a),
    .b_i      (b),
    .done_o   (md_done),
    .res_o    (md_res)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      r_q         <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (is_iter_op(op)) begin
              state_q <= ST_BUSY;
            end else begin
              r_q         <= single_res;
              out_valid_q <= 1'b1;
              state_q     <= ST_DONE;
            end
          end
        end
        ST_BUSY: begin
          if (md_done) begin
            r_q         <= md_res;
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_q         <= '0;
            out_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          r_q         <= '0;
          out_valid_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
